// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply and restoring divide,
// XLEN steps per op, followed by a sign-fix cycle and a one-cycle registered result.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            StartE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            MdStallE,
    output logic            MdValidE,
    output logic [XLEN-1:0] MdResultE
);
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    localparam logic [XLEN-1:0] ZERO_C = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_C = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_C  = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [2:0]        f3_r;
    logic [XLEN-1:0]   hi_r, lo_r, b_r, res_r;
    logic              neg_a_r, neg_b_r, valid_r;

    logic              accept_s, sign_a_s, sign_b_s, neg_a_s, neg_b_s;
    logic              div_zero_s, ovf_s, special_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s, special_res_s;
    logic [XLEN:0]     sum_s, shifted_s, diff_s;
    logic [XLEN-1:0]   step_hi_s, step_lo_s, quo_fix_s, rem_fix_s, fix_res_s;
    logic [2*XLEN-1:0] prod_fix_s;

    assign accept_s = StartE & ~FlushE & ((state_r == IDLE) | (state_r == DONE));
    assign MdStallE = ~FlushE & ((state_r == CALC) | (state_r == FIX) | accept_s);
    assign MdValidE = valid_r;
    assign MdResultE = res_r;

    // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed
    assign sign_a_s = (funct3E == 3'b001) | (funct3E == 3'b010) | (funct3E == 3'b100) | (funct3E == 3'b110);
    assign sign_b_s = (funct3E == 3'b001) | (funct3E == 3'b100) | (funct3E == 3'b110);
    assign neg_a_s  = sign_a_s & SrcAE[XLEN-1];
    assign neg_b_s  = sign_b_s & SrcBE[XLEN-1];
    assign mag_a_s  = neg_a_s ? (ZERO_C - SrcAE) : SrcAE;
    assign mag_b_s  = neg_b_s ? (ZERO_C - SrcBE) : SrcBE;

    assign div_zero_s = funct3E[2] & (SrcBE == ZERO_C);
    assign ovf_s      = funct3E[2] & ~funct3E[0] & (SrcAE == MIN_C) & (SrcBE == ONES_C);
    assign special_s  = div_zero_s | ovf_s;

    // Result of ops that bypass the iteration (divide by zero, signed overflow)
    always_comb begin
        special_res_s = ZERO_C;
        if (div_zero_s) begin
            special_res_s = funct3E[1] ? SrcAE : ONES_C;
        end else begin
            special_res_s = funct3E[1] ? ZERO_C : MIN_C;
        end
    end

    // One iteration step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        sum_s     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
        shifted_s = {hi_r, lo_r[XLEN-1]};
        diff_s    = shifted_s - {1'b0, b_r};
        step_hi_s = sum_s[XLEN:1];
        step_lo_s = {sum_s[0], lo_r[XLEN-1:1]};
        if (f3_r[2]) begin
            step_hi_s = diff_s[XLEN] ? {hi_r[XLEN-2:0], lo_r[XLEN-1]} : diff_s[XLEN-1:0];
            step_lo_s = {lo_r[XLEN-2:0], ~diff_s[XLEN]};
        end else begin
            step_hi_s = sum_s[XLEN:1];
            step_lo_s = {sum_s[0], lo_r[XLEN-1:1]};
        end
    end

    assign prod_fix_s = (neg_a_r ^ neg_b_r) ? ({(2*XLEN){1'b0}} - {hi_r, lo_r}) : {hi_r, lo_r};
    assign quo_fix_s  = (neg_a_r ^ neg_b_r) ? (ZERO_C - lo_r) : lo_r;
    assign rem_fix_s  = neg_a_r ? (ZERO_C - hi_r) : hi_r;

    // Final result select after sign correction
    always_comb begin
        fix_res_s = ZERO_C;
        case (f3_r)
            3'b000:                 fix_res_s = prod_fix_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res_s = quo_fix_s;
            3'b110, 3'b111:         fix_res_s = rem_fix_s;
            default:                fix_res_s = ZERO_C;
        endcase
    end

    // Sequencer FSM and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            f3_r    <= 3'b000;
            hi_r    <= ZERO_C;
            lo_r    <= ZERO_C;
            b_r     <= ZERO_C;
            res_r   <= ZERO_C;
            neg_a_r <= 1'b0;
            neg_b_r <= 1'b0;
            valid_r <= 1'b0;
        end else if (FlushE) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    valid_r <= 1'b0;
                    if (StartE) begin
                        f3_r    <= funct3E;
                        neg_a_r <= neg_a_s;
                        neg_b_r <= neg_b_s;
                        b_r     <= mag_b_s;
                        hi_r    <= ZERO_C;
                        lo_r    <= mag_a_s;
                        cnt_r   <= CNT_W'(XLEN);
                        if (special_s) begin
                            res_r   <= special_res_s;
                            valid_r <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            state_r <= CALC;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    hi_r  <= step_hi_s;
                    lo_r  <= step_lo_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= CALC;
                    end
                end
                FIX: begin
                    res_r   <= fix_res_s;
                    valid_r <= 1'b1;
                    state_r <= DONE;
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
